// File: rtl/pulse_train_pkg.sv
// Shared types and constants for the pulse train generator.
// Timestamp width applies only when PULSE_TRAIN_TIMESTAMP_EN is defined.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  localparam int TS_W = 32;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..max(div,1)-1 and emits a registered
// one-cycle tick while the counter sits at its last value.
module tick_prescaler #(
  parameter int DIV_W = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_nxt_s;
  logic [DIV_W-1:0] last_s;
  logic             tick_r;
  logic             tick_nxt_s;

  // Next counter value; a counter at or above the new last value wraps
  // immediately so a shrinking divisor never stalls the prescaler.
  always_comb begin
    last_s     = '0;
    cnt_nxt_s  = '0;
    tick_nxt_s = 1'b0;
    if (div == '0) begin
      last_s = '0;
    end else begin
      last_s = div - DIV_ONE;
    end
    if (cnt_r >= last_s) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + DIV_ONE;
    end
    tick_nxt_s = (cnt_nxt_s == last_s);
  end

  // Counter and tick registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= tick_nxt_s;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator sharing one prescaler tick.
// Optional feature: define PULSE_TRAIN_TIMESTAMP_EN to add per-channel done timestamps (port ts).
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int DIV_W = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_W-1:0]     div,
  input  logic [NCH-1:0]       start,
  input  logic [NCH*CNT_W-1:0] count,
  output logic                 tick,
`ifdef PULSE_TRAIN_TIMESTAMP_EN
  output logic [NCH*TS_W-1:0]  ts,
`endif
  output logic [NCH-1:0]       pulse_out,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic tick_s;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (div),
    .tick    (tick_s)
  );

  assign tick = tick_s;

`ifdef PULSE_TRAIN_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_r;

  // Free-running cycle counter used as the timestamp base
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_cnt_r <= '0;
    end else begin
      ts_cnt_r <= ts_cnt_r + 32'd1;
    end
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e        state_r;
    ch_state_e        state_nxt_s;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] rem_nxt_s;
    logic [CNT_W-1:0] count_s;
    logic             pulse_r;
    logic             pulse_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    assign count_s = count[i*CNT_W +: CNT_W];

    // Channel FSM: outputs are decoded from the next state and registered
    always_comb begin
      state_nxt_s = state_r;
      rem_nxt_s   = rem_r;
      pulse_nxt_s = pulse_r;
      busy_nxt_s  = 1'b0;
      done_nxt_s  = 1'b0;
      case (state_r)
        IDLE: begin
          pulse_nxt_s = 1'b0;
          if (start[i]) begin
            rem_nxt_s = count_s;
            if (count_s != '0) begin
              state_nxt_s = RUN;
              busy_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = DONE;
              done_nxt_s  = 1'b1;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          busy_nxt_s = 1'b1;
          if (tick_s) begin
            if (!pulse_r) begin
              pulse_nxt_s = 1'b1;
            end else begin
              // falling edge completes one pulse
              pulse_nxt_s = 1'b0;
              rem_nxt_s   = rem_r - CNT_ONE;
              if (rem_r == CNT_ONE) begin
                state_nxt_s = DONE;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b1;
              end else begin
                state_nxt_s = RUN;
              end
            end
          end else begin
            pulse_nxt_s = pulse_r;
          end
        end
        DONE: begin
          state_nxt_s = IDLE;
          pulse_nxt_s = 1'b0;
          rem_nxt_s   = '0;
        end
        default: begin
          state_nxt_s = IDLE;
          pulse_nxt_s = 1'b0;
          rem_nxt_s   = '0;
        end
      endcase
    end

    // Channel state and output registers
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_r <= IDLE;
        rem_r   <= '0;
        pulse_r <= 1'b0;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        rem_r   <= rem_nxt_s;
        pulse_r <= pulse_nxt_s;
        busy_r  <= busy_nxt_s;
        done_r  <= done_nxt_s;
      end
    end

    assign pulse_out[i] = pulse_r;
    assign busy[i]      = busy_r;
    assign done[i]      = done_r;

`ifdef PULSE_TRAIN_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r;

    // Capture lands together with done, holding the counter value of that cycle
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        ts_r <= '0;
      end else if (done_nxt_s) begin
        ts_r <= ts_cnt_r + 32'd1;
      end else begin
        ts_r <= ts_r;
      end
    end

    assign ts[i*TS_W +: TS_W] = ts_r;
`endif
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen; covers the timestamp
// outputs too when PULSE_TRAIN_TIMESTAMP_EN is defined.
module tb_pulse_train_gen;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;
  localparam int DIV_W = 31;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [DIV_W-1:0]     div;
  logic [NCH-1:0]       start;
  logic [NCH*CNT_W-1:0] count;
  logic                 tick;
  logic [NCH-1:0]       pulse_out;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;
`ifdef PULSE_TRAIN_TIMESTAMP_EN
  logic [NCH*32-1:0]    ts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(
    .NCH   (NCH),
    .CNT_W (CNT_W),
    .DIV_W (DIV_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .div       (div),
    .start     (start),
    .count     (count),
    .tick      (tick),
`ifdef PULSE_TRAIN_TIMESTAMP_EN
    .ts        (ts),
`endif
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic set_count(input int ch, input logic [CNT_W-1:0] v);
    count[ch*CNT_W +: CNT_W] = v;
  endtask

  // Samples one channel at each falling edge until done, measuring pulse shape.
  task automatic observe(input int ch, input int budget, output bit found,
                         output int highs, output int hi_min, output int hi_max,
                         output int lo_min, output int lo_max, output int ncyc,
                         output logic b_at, output logic p_at);
    int cur_hi;
    int cur_lo;
    found = 1'b0; highs = 0; hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    ncyc = 0; cur_hi = 0; cur_lo = 0; b_at = 1'bx; p_at = 1'bx;
    for (int k = 1; k <= budget; k++) begin
      if (pulse_out[ch]) begin
        if (cur_lo > 0 && highs > 0) begin
          if (cur_lo < lo_min) lo_min = cur_lo;
          if (cur_lo > lo_max) lo_max = cur_lo;
        end
        cur_lo = 0;
        cur_hi++;
      end else begin
        if (cur_hi > 0) begin
          highs++;
          if (cur_hi < hi_min) hi_min = cur_hi;
          if (cur_hi > hi_max) hi_max = cur_hi;
        end
        cur_hi = 0;
        cur_lo++;
      end
      if (done[ch]) begin
        found = 1'b1; ncyc = k; b_at = busy[ch]; p_at = pulse_out[ch];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; div = 31'd4; start = 4'hF;
    count = {16'd3, 16'd3, 16'd3, 16'd3};
    @(negedge clk);
    checks++;
    if ({tick, pulse_out, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got tick=%b pulse=%b busy=%b done=%b, want all 0",
               tick, pulse_out, busy, done);
    end
    start = 4'h0;
  endtask

  task automatic test_prescaler();
    logic [8:0] exp_ticks;
    bit seen;
    logic [3:0] exp_after;
    exp_ticks = 9'b100100100;
    div = 31'd3; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (tick !== exp_ticks[k]) begin
        errors++;
        $display("FAIL prescaler_div3 cycle %0d: tick=%b want %b", k, tick, exp_ticks[k]);
      end
      @(negedge clk);
    end
    // shrink the divisor while the counter is high
    div = 31'd8;
    repeat (2) @(negedge clk);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (tick) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL prescaler_div8_tick: no tick within 20 cycles, want one");
    end
    repeat (6) @(negedge clk);
    div = 31'd2;
    exp_after = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (tick !== exp_after[k]) begin
        errors++;
        $display("FAIL prescaler_shrink cycle %0d: tick=%b want %b", k, tick, exp_after[k]);
      end
    end
  endtask

  task automatic test_single_train();
    bit found; int highs, hmin, hmax, lmin, lmax, ncyc; logic b_at, p_at;
    div = 31'd4; set_count(0, 16'd3);
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL single_busy_next: busy[0]=%b want 1", busy[0]);
    end
    observe(0, 200, found, highs, hmin, hmax, lmin, lmax, ncyc, b_at, p_at);
    checks++;
    if (!found) begin
      errors++; $display("FAIL single_done_seen: done[0] not seen in 200 cycles, want 1");
    end
    checks++;
    if (highs !== 3) begin
      errors++; $display("FAIL single_pulse_count: got %0d want 3", highs);
    end
    checks++;
    if (hmin !== 4 || hmax !== 4 || lmin !== 4 || lmax !== 4) begin
      errors++;
      $display("FAIL single_widths: high %0d..%0d low %0d..%0d want 4", hmin, hmax, lmin, lmax);
    end
    checks++;
    if (b_at !== 1'b0 || p_at !== 1'b0) begin
      errors++; $display("FAIL single_at_done: busy=%b pulse=%b want 0 0", b_at, p_at);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++; $display("FAIL single_after: busy=%b done=%b want 0 0", busy[0], done[0]);
    end
  endtask

  task automatic test_zero_count();
    set_count(1, 16'd0);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    checks++;
    if (done[1] !== 1'b1 || busy[1] !== 1'b0 || pulse_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b pulse=%b want 1 0 0", done[1], busy[1], pulse_out[1]);
    end
    @(negedge clk);
    checks++;
    if (done[1] !== 1'b0 || busy[1] !== 1'b0 || pulse_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: done=%b busy=%b pulse=%b want 0 0 0", done[1], busy[1], pulse_out[1]);
    end
  endtask

  task automatic test_small_div();
    bit found; int highs, hmin, hmax, lmin, lmax, ncyc; logic b_at, p_at;
    for (int d = 0; d < 2; d++) begin
      div = DIV_W'(d);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (tick !== 1'b1) begin
          errors++; $display("FAIL smalldiv%0d_tick: tick=%b want 1", d, tick);
        end
        @(negedge clk);
      end
      set_count(2, 16'd2);
      start[2] = 1'b1;
      @(negedge clk);
      start[2] = 1'b0;
      checks++;
      if (busy[2] !== 1'b1 || pulse_out[2] !== 1'b0) begin
        errors++;
        $display("FAIL smalldiv%0d_first: busy=%b pulse=%b want 1 0", d, busy[2], pulse_out[2]);
      end
      observe(2, 50, found, highs, hmin, hmax, lmin, lmax, ncyc, b_at, p_at);
      checks++;
      if (!found || highs !== 2 || hmin !== 1 || hmax !== 1 || lmin !== 1 || ncyc !== 5) begin
        errors++;
        $display("FAIL smalldiv%0d_train: found=%0d highs=%0d hi=%0d..%0d lo=%0d done_at=%0d want 1 2 1..1 1 5",
                 d, found, highs, hmin, hmax, lmin, ncyc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    int rises; int ndone; logic prev;
    div = 31'd4; set_count(2, 16'd5);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 100 && rises < 2; k++) begin
      if (pulse_out[2] && !prev) rises++;
      prev = pulse_out[2];
      if (rises < 2) @(negedge clk);
    end
    checks++;
    if (rises !== 2) begin
      errors++; $display("FAIL midreset_pulse2: saw %0d rises want 2", rises);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({tick, pulse_out, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_outputs: tick=%b pulse=%b busy=%b done=%b want all 0",
               tick, pulse_out, busy, done);
    end
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done != 4'h0 || busy != 4'h0) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL midreset_no_done: %0d cycles with done/busy, want 0", ndone);
    end
  endtask

  task automatic test_concurrent();
    int done_at [NCH];
    int ndone [NCH];
    int rises [NCH];
    logic [NCH-1:0] prev;
    logic [31:0] ts_at [NCH];
    int alldone;
    div = 31'd2;
    count = {16'd4, 16'd3, 16'd2, 16'd1};
    repeat (2) @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      done_at[i] = -1; ndone[i] = 0; rises[i] = 0; ts_at[i] = 32'd0;
    end
    prev = 4'h0;
    start = 4'hF;
    @(negedge clk);
    start = 4'h0;
    alldone = 0;
    for (int k = 1; k <= 120; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (pulse_out[i] && !prev[i]) rises[i]++;
        if (done[i]) begin
          ndone[i]++;
          if (done_at[i] < 0) done_at[i] = k;
`ifdef PULSE_TRAIN_TIMESTAMP_EN
          ts_at[i] = ts[i*32 +: 32];
`endif
        end
      end
      prev = pulse_out;
      if (k == 2) start = 4'hF;
      if (k == 3) start = 4'h0;
      if (done_at[NCH-1] >= 0 && alldone == 0) alldone = k;
      if (alldone > 0 && k >= alldone + 10) break;
      @(negedge clk);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (ndone[i] !== 1 || rises[i] !== i + 1) begin
        errors++;
        $display("FAIL conc_ch%0d: dones=%0d pulses=%0d want 1 %0d", i, ndone[i], rises[i], i + 1);
      end
    end
    for (int i = 1; i < NCH; i++) begin
      checks++;
      if (done_at[i] - done_at[i-1] !== 4) begin
        errors++;
        $display("FAIL conc_spacing%0d: done gap %0d want 4", i, done_at[i] - done_at[i-1]);
      end
`ifdef PULSE_TRAIN_TIMESTAMP_EN
      checks++;
      if (ts_at[i] - ts_at[i-1] !== 32'd4) begin
        errors++;
        $display("FAIL conc_ts_gap%0d: ts gap %0d want 4", i, ts_at[i] - ts_at[i-1]);
      end
      checks++;
      if (ts[i*32 +: 32] !== ts_at[i]) begin
        errors++;
        $display("FAIL conc_ts_hold%0d: ts=%0d want %0d", i, ts[i*32 +: 32], ts_at[i]);
      end
`endif
    end
    checks++;
    if (busy !== 4'h0) begin
      errors++; $display("FAIL conc_idle_end: busy=%b want 0000", busy);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    div = 31'd1; set_count(3, 16'd1);
    repeat (2) @(negedge clk);
    d1 = -1; d2 = -1;
    start[3] = 1'b1;
    for (int k = 0; k < 40 && d2 < 0; k++) begin
      @(negedge clk);
      if (done[3]) begin
        if (d1 < 0) d1 = k;
        else d2 = k;
      end
    end
    start[3] = 1'b0;
    checks++;
    if (d1 < 0 || d2 < 0 || d2 - d1 !== 4) begin
      errors++; $display("FAIL b2b_restart: done at %0d and %0d, want gap 4", d1, d2);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy[3] !== 1'b0 || done[3] !== 1'b0) begin
      errors++; $display("FAIL b2b_release: busy=%b done=%b want 0 0", busy[3], done[3]);
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_single_train();
    test_zero_count();
    test_small_div();
    test_mid_reset();
    test_concurrent();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
